vga_pixel_fetch: RTL

- Downstream consumer of the VGA timing generator.
- Inputs: the generator's h/v counters, can_color, hsync and vsync.
- Prefetches the next display line from framebuffer memory into a ping-pong line buffer over a req/ack read port. Meanwhile it serves the current line from the other bank.
- Outputs gated RGB plus delayed sync/DE signals, all aligned, to the DAC/pin stage.

---
 rtl/vga_pixel_fetch_pkg.sv | 29 ++
 rtl/vga_line_buffer.sv | 37 +++
 rtl/vga_pixel_fetch.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/vga_pixel_fetch_pkg.sv
// Shared definitions for the VGA pixel fetch path: line geometry helper,
// fetch FSM states and RGB444 lane extraction from a packed memory word.
package vga_pixel_fetch_pkg;

    typedef enum logic {
        FETCH_IDLE,
        FETCH_REQ
    } fetch_state_t;

    localparam int unsigned RGB_BITS  = 12;
    localparam int unsigned MAX_LANES = 8;

    // Words of framebuffer memory needed to hold one visible line.
    function automatic int unsigned line_words(input int unsigned pixels,
                                               input int unsigned per_word);
        return pixels / per_word;
    endfunction

    // Pixel 0 sits in the least significant bits of the word.
    function automatic logic [RGB_BITS-1:0] rgb444_lane(
        input logic [RGB_BITS*MAX_LANES-1:0] word,
        input logic [2:0]                    lane
    );
        logic [RGB_BITS*MAX_LANES-1:0] shifted;
        shifted = word >> (lane * RGB_BITS);
        return shifted[RGB_BITS-1:0];
    endfunction

endpackage

// File: rtl/vga_line_buffer.sv
// Ping-pong line buffer: two banks of WORDS entries, one write port and one
// synchronous read port with a single cycle of read latency.
module vga_line_buffer #(
    parameter int unsigned WORDS     = 320,
    parameter int unsigned DATA_BITS = 48
) (
    input  logic                                    clk,
    input  logic                                    wr_en,
    input  logic                                    wr_bank,
    input  logic [((WORDS > 1) ? $clog2(WORDS) : 1)-1:0] wr_word,
    input  logic [DATA_BITS-1:0]                    wr_data,
    input  logic                                    rd_bank,
    input  logic [((WORDS > 1) ? $clog2(WORDS) : 1)-1:0] rd_word,
    output logic [DATA_BITS-1:0]                    rd_data
);

    localparam int unsigned IDX_BITS = $clog2(2 * WORDS);

    logic [DATA_BITS-1:0] mem [2*WORDS];
    logic [IDX_BITS-1:0]  wr_idx;
    logic [IDX_BITS-1:0]  rd_idx;

    // Bank 1 occupies the upper WORDS entries of the shared array.
    always_comb begin
        wr_idx = wr_bank ? IDX_BITS'(WORDS) + IDX_BITS'(wr_word) : IDX_BITS'(wr_word);
        rd_idx = rd_bank ? IDX_BITS'(WORDS) + IDX_BITS'(rd_word) : IDX_BITS'(rd_word);
    end

    // Write and registered read; contents are intentionally never cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
        rd_data <= mem[rd_idx];
    end

endmodule

// File: rtl/vga_pixel_fetch.sv
// Fetches the next display line from framebuffer memory into one bank of a
// ping-pong buffer while the other bank feeds a 2-stage pixel pipeline whose
// RGB, DE and sync outputs stay mutually aligned.
module vga_pixel_fetch
    import vga_pixel_fetch_pkg::*;
#(
    parameter int unsigned LINE_PIXELS   = 1280,
    parameter int unsigned VISIBLE_LINES = 1024,
    parameter int unsigned WHOLE_FRAME   = 1066,
    parameter int unsigned PIX_BITS      = 12,
    parameter int unsigned PIX_PER_WORD  = 4,
    parameter int unsigned ADDR_BITS     = 20,
    parameter int unsigned FB_BASE       = 0,
    parameter int unsigned LINE_STRIDE   = 320,
    parameter logic        HSYNC_IDLE    = 1'b1,
    parameter logic        VSYNC_IDLE    = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [11:0]                      h_counter,
    input  logic [11:0]                      v_counter,
    input  logic                             can_color,
    input  logic                             hsync_in,
    input  logic                             vsync_in,
    output logic                             mem_req,
    output logic [ADDR_BITS-1:0]             mem_addr,
    input  logic                             mem_ack,
    input  logic [PIX_BITS*PIX_PER_WORD-1:0] mem_rdata,
    output logic [PIX_BITS-1:0]              rgb_out,
    output logic                             de_out,
    output logic                             hsync_out,
    output logic                             vsync_out,
    output logic                             underrun
);

    localparam int unsigned LINE_WORDS = line_words(LINE_PIXELS, PIX_PER_WORD);
    localparam int unsigned WORD_BITS  = PIX_BITS * PIX_PER_WORD;
    localparam int unsigned WB         = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int unsigned LANE_BITS  = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;

    localparam logic [11:0]   LAST_PREFETCH_V = 12'(VISIBLE_LINES - 1);
    localparam logic [11:0]   LAST_FRAME_V    = 12'(WHOLE_FRAME - 1);
    localparam logic [11:0]   LINE_PIX_12     = 12'(LINE_PIXELS);
    localparam logic [11:0]   PPW_12          = 12'(PIX_PER_WORD);
    localparam logic [WB-1:0] LAST_WORD       = WB'(LINE_WORDS - 1);

    if (LINE_PIXELS % PIX_PER_WORD != 0) begin : g_bad_line_words
        $error("LINE_PIXELS must be an exact multiple of PIX_PER_WORD");
    end
    if (PIX_BITS != RGB_BITS || PIX_PER_WORD > MAX_LANES) begin : g_bad_pixel_format
        $error("pixel format must be RGB444 with at most MAX_LANES pixels per word");
    end

    fetch_state_t          state;
    logic                  fetch_bank;
    logic [WB-1:0]         fetch_word;
    logic                  trigger;
    logic [11:0]           next_line;
    logic [ADDR_BITS-1:0]  next_base;
    logic                  wr_en;

    logic [WB-1:0]         rd_word;
    logic [WORD_BITS-1:0]  rd_data;
    logic [LANE_BITS-1:0]  s1_lane;
    logic                  s1_de;
    logic                  s1_hs;
    logic                  s1_vs;
    logic                  s1_vis;

    // Start-of-line fetch decision and the line base address, computed once here.
    always_comb begin
        trigger   = 1'b0;
        next_line = '0;
        if (h_counter == '0) begin
            if (v_counter < LAST_PREFETCH_V) begin
                trigger   = 1'b1;
                next_line = v_counter + 12'd1;
            end else if (v_counter == LAST_FRAME_V) begin
                trigger   = 1'b1;
                next_line = '0;
            end
        end
        next_base = ADDR_BITS'(FB_BASE) + ADDR_BITS'(next_line) * ADDR_BITS'(LINE_STRIDE);
    end

    assign wr_en = (state == FETCH_REQ) && mem_ack;

    // Fetch FSM. mem_addr is loaded with the line base and then stepped by one per
    // accepted word, so it always equals base + word index without a second adder.
    // An ack coinciding with a trigger still lands via wr_en before the restart.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH_IDLE;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            underrun   <= 1'b0;
            fetch_bank <= 1'b0;
            fetch_word <= '0;
        end else begin
            underrun <= 1'b0;
            if (trigger) begin
                underrun   <= (state == FETCH_REQ);
                state      <= FETCH_REQ;
                mem_req    <= 1'b1;
                mem_addr   <= next_base;
                fetch_bank <= next_line[0];
                fetch_word <= '0;
            end else if (wr_en) begin
                if (fetch_word == LAST_WORD) begin
                    state   <= FETCH_IDLE;
                    mem_req <= 1'b0;
                end else begin
                    fetch_word <= fetch_word + 1'b1;
                    mem_addr   <= mem_addr + 1'b1;
                end
            end
        end
    end

    vga_line_buffer #(
        .WORDS     (LINE_WORDS),
        .DATA_BITS (WORD_BITS)
    ) u_line_buffer (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_bank (fetch_bank),
        .wr_word (fetch_word),
        .wr_data (mem_rdata),
        .rd_bank (v_counter[0]),
        .rd_word (rd_word),
        .rd_data (rd_data)
    );

    // Word address for the display read; off-screen columns read word 0 harmlessly.
    always_comb begin
        rd_word = '0;
        if (h_counter < LINE_PIX_12) begin
            rd_word = WB'(h_counter / PPW_12);
        end
    end

    // Two-stage display pipeline: stage 1 alongside the RAM read, stage 2 selects and gates.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_lane   <= '0;
            s1_de     <= 1'b0;
            s1_hs     <= HSYNC_IDLE;
            s1_vs     <= VSYNC_IDLE;
            s1_vis    <= 1'b0;
            rgb_out   <= '0;
            de_out    <= 1'b0;
            hsync_out <= HSYNC_IDLE;
            vsync_out <= VSYNC_IDLE;
        end else begin
            s1_lane   <= LANE_BITS'(h_counter % PPW_12);
            s1_de     <= can_color;
            s1_hs     <= hsync_in;
            s1_vs     <= vsync_in;
            s1_vis    <= (h_counter < LINE_PIX_12);
            rgb_out   <= (s1_de && s1_vis)
                         ? rgb444_lane((RGB_BITS*MAX_LANES)'(rd_data), 3'(s1_lane))
                         : '0;
            de_out    <= s1_de;
            hsync_out <= s1_hs;
            vsync_out <= s1_vs;
        end
    end

endmodule
